// File: rtl/game_pkg.sv
// Shared definitions for the game core and the command issuer: state codes,
// command codes and default timing constants.
package game_pkg;

  typedef enum logic [2:0] {
    ST_READY   = 3'd0,
    ST_PLAYING = 3'd1,
    ST_OVER    = 3'd3,
    ST_SCLEAR  = 3'd4,
    ST_GCLEAR  = 3'd5
  } game_state_e;

  typedef enum logic [3:0] {
    CMD_SCORE  = 4'b0001,
    CMD_LOSE   = 4'b0010,
    CMD_COUNT  = 4'b0101,
    CMD_READY  = 4'b1000,
    CMD_PLAY   = 4'b1010,
    CMD_SCLEAR = 4'b1100,
    CMD_OVER   = 4'b1101,
    CMD_GCLEAR = 4'b1110
  } cmd_e;

  localparam int READY_SEC_DEF = 3;
  localparam int PLAY_SEC0_DEF = 30;
  localparam int PLAY_SEC1_DEF = 25;
  localparam int PLAY_SEC2_DEF = 20;
  localparam int PLAY_SEC3_DEF = 15;

  localparam logic [9:0] SCORE_MAX  = 10'd999;
  localparam logic [1:0] LIVES_INIT = 2'd3;
  localparam logic [1:0] STAGE_MAX  = 2'd3;

endpackage

// File: rtl/sec_ticker.sv
// One-second prescaler: tick_o strobes combinationally on the wrap cycle,
// sec_pulse_o is that strobe registered so it lines up with the new timer value.
module sec_ticker #(
  parameter int TICK_DIV = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o,
  output logic sec_pulse_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q;
  logic          wrap;

  assign wrap   = (cnt_q == CW'(TICK_DIV - 1));
  // A clear on the wrap cycle wins: no tick, counter restarts.
  assign tick_o = enable_i && wrap && !clear_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = wrap ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= tick_o;
    end
  end

  assign sec_pulse_o = pulse_q;

endmodule

// File: rtl/game_state_core.sv
// Game state machine: command decode with per-state legality, score/lives
// bookkeeping and a seconds countdown driven by sec_ticker.
module game_state_core
  import game_pkg::*;
#(
  parameter int TICK_DIV  = 1000000,
  parameter int READY_SEC = READY_SEC_DEF,
  parameter int PLAY_SEC0 = PLAY_SEC0_DEF,
  parameter int PLAY_SEC1 = PLAY_SEC1_DEF,
  parameter int PLAY_SEC2 = PLAY_SEC2_DEF,
  parameter int PLAY_SEC3 = PLAY_SEC3_DEF
) (
  input  logic       clk_1mhz,
  input  logic       rst_n,
  input  logic [3:0] flag,
  input  logic       trig,
  output logic       done,
  output logic       sec_posedge,
  output logic       timer_running,
  output logic [6:0] timer,
  output logic [2:0] state,
  output logic [1:0] stage,
  output logic [1:0] lives,
  output logic [9:0] score
);

  localparam logic [6:0] PLAY_TAB [4] = '{7'(PLAY_SEC0), 7'(PLAY_SEC1),
                                          7'(PLAY_SEC2), 7'(PLAY_SEC3)};

  game_state_e state_q, state_d;
  logic [1:0]  stage_q, stage_d;
  logic [1:0]  lives_q, lives_d;
  logic [9:0]  score_q, score_d;
  logic [6:0]  timer_q, timer_d;
  logic        run_q, run_d;
  logic        done_q;
  logic        accept, load, tick, sec_pulse;

  // Legality depends only on current state, so a held command self-blocks
  // once it has moved the machine on.
  always_comb begin
    accept = 1'b0;
    load   = 1'b0;
    if (trig) begin
      case (flag)
        CMD_SCORE, CMD_LOSE:
          accept = (state_q == ST_PLAYING);
        CMD_SCLEAR, CMD_OVER, CMD_GCLEAR: begin
          accept = (state_q == ST_PLAYING);
          load   = accept;
        end
        CMD_COUNT: begin
          accept = (state_q == ST_READY) && !run_q && (timer_q != 7'd0);
          load   = accept;
        end
        CMD_PLAY: begin
          accept = (state_q == ST_READY) && !run_q && (timer_q == 7'd0);
          load   = accept;
        end
        CMD_READY: begin
          accept = (state_q == ST_OVER) || (state_q == ST_SCLEAR) ||
                   (state_q == ST_GCLEAR);
          load   = accept;
        end
        default: begin
          accept = 1'b0;
          load   = 1'b0;
        end
      endcase
    end
  end

  sec_ticker #(.TICK_DIV(TICK_DIV)) u_ticker (
    .clk_i       (clk_1mhz),
    .rst_ni      (rst_n),
    .clear_i     (load),
    .enable_i    (run_q),
    .tick_o      (tick),
    .sec_pulse_o (sec_pulse)
  );

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    lives_d = lives_q;
    score_d = score_q;
    timer_d = timer_q;
    run_d   = run_q;
    if (tick) begin
      timer_d = timer_q - 7'd1;
      if (timer_q == 7'd1) run_d = 1'b0;
    end
    if (accept) begin
      case (flag)
        CMD_SCORE:  if (score_q != SCORE_MAX) score_d = score_q + 10'd1;
        CMD_LOSE:   if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
        CMD_COUNT:  run_d = 1'b1;
        CMD_PLAY: begin
          state_d = ST_PLAYING;
          timer_d = PLAY_TAB[stage_q];
          run_d   = 1'b1;
        end
        CMD_SCLEAR: begin state_d = ST_SCLEAR; run_d = 1'b0; end
        CMD_OVER:   begin state_d = ST_OVER;   run_d = 1'b0; end
        CMD_GCLEAR: begin state_d = ST_GCLEAR; run_d = 1'b0; end
        CMD_READY: begin
          if (state_q == ST_SCLEAR) begin
            if (stage_q != STAGE_MAX) stage_d = stage_q + 2'd1;
          end else begin
            stage_d = 2'd0;
            lives_d = LIVES_INIT;
            score_d = '0;
          end
          state_d = ST_READY;
          timer_d = 7'(READY_SEC);
          run_d   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_READY;
      stage_q <= 2'd0;
      lives_q <= LIVES_INIT;
      score_q <= '0;
      timer_q <= 7'(READY_SEC);
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      lives_q <= lives_d;
      score_q <= score_d;
      timer_q <= timer_d;
      run_q   <= run_d;
      done_q  <= accept;
    end
  end

  assign done          = done_q;
  assign sec_posedge   = sec_pulse;
  assign timer_running = run_q;
  assign timer         = timer_q;
  assign state         = state_q;
  assign stage         = stage_q;
  assign lives         = lives_q;
  assign score         = score_q;

endmodule

// File: tb/tb_game_state_core.sv
// Bench for game_state_core: directed scenarios plus random commands, all
// checked each cycle against a behavioural model of the game rules.
module tb_game_state_core;

  localparam int TICK_DIV = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] flag = 4'd0;
  logic       trig = 1'b0;
  logic       done, sec_posedge, timer_running;
  logic [6:0] timer;
  logic [2:0] state;
  logic [1:0] stage, lives;
  logic [9:0] score;

  game_state_core #(.TICK_DIV(TICK_DIV)) dut (
    .clk_1mhz      (clk),
    .rst_n         (rst_n),
    .flag          (flag),
    .trig          (trig),
    .done          (done),
    .sec_posedge   (sec_posedge),
    .timer_running (timer_running),
    .timer         (timer),
    .state         (state),
    .stage         (stage),
    .lives         (lives),
    .score         (score)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sec_cnt = 0;
  int done_cnt = 0;

  int play_sec [4] = '{30, 25, 20, 15};
  int m_state, m_stage, m_lives, m_score, m_timer, m_presc;
  bit m_run, m_done, m_sec;

  task automatic check(input string tag, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_stage = 0; m_lives = 3; m_score = 0;
    m_timer = 3; m_presc = 0; m_run = 0; m_done = 0; m_sec = 0;
  endtask

  function automatic bit legal(input int f);
    case (f)
      1, 2, 12, 13, 14: return m_state == 1;
      5:                return m_state == 0 && !m_run && m_timer > 0;
      10:               return m_state == 0 && !m_run && m_timer == 0;
      8:                return m_state == 3 || m_state == 4 || m_state == 5;
      default:          return 0;
    endcase
  endfunction

  task automatic model_step(input int f, input bit t);
    bit acc, ld, wrap;
    acc  = t && legal(f);
    ld   = acc && (f == 5 || f == 10 || f == 8 || f == 12 || f == 13 || f == 14);
    wrap = m_run && (m_presc == TICK_DIV - 1);
    m_done = acc;
    m_sec  = wrap && !ld;
    if (ld) m_presc = 0;
    else if (m_run) m_presc = wrap ? 0 : m_presc + 1;
    if (m_sec) begin
      m_timer--;
      if (m_timer == 0) m_run = 0;
    end
    if (acc) begin
      case (f)
        1:  m_score = (m_score < 999) ? m_score + 1 : 999;
        2:  m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        5:  m_run = 1;
        10: begin m_state = 1; m_timer = play_sec[m_stage]; m_run = 1; end
        12: begin m_state = 4; m_run = 0; end
        13: begin m_state = 3; m_run = 0; end
        14: begin m_state = 5; m_run = 0; end
        8: begin
          if (m_state == 4) m_stage = (m_stage < 3) ? m_stage + 1 : 3;
          else begin m_stage = 0; m_lives = 3; m_score = 0; end
          m_state = 0; m_timer = 3; m_run = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    check("done",  32'(done),          int'(m_done));
    check("sec",   32'(sec_posedge),   int'(m_sec));
    check("run",   32'(timer_running), int'(m_run));
    check("timer", 32'(timer),         m_timer);
    check("state", 32'(state),         m_state);
    check("stage", 32'(stage),         m_stage);
    check("lives", 32'(lives),         m_lives);
    check("score", 32'(score),         m_score);
  endtask

  task automatic cyc(input logic [3:0] f, input bit t);
    flag = f;
    trig = t;
    model_step(int'(f), t);
    @(posedge clk);
    #1;
    if (sec_posedge === 1'b1) sec_cnt++;
    if (done === 1'b1) done_cnt++;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'd0, 1'b0);
  endtask

  task automatic async_reset();
    #3 rst_n = 1'b0;
    flag = 4'd0;
    trig = 1'b0;
    model_reset();
    #1 compare_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [3:0] codes [8] = '{4'b0001, 4'b0010, 4'b0101, 4'b1010,
                           4'b1100, 4'b1101, 4'b1110, 4'b1000};

  initial begin
    model_reset();
    #12 compare_all();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Ready countdown 3..0
    sec_cnt = 0;
    cyc(4'b0101, 1'b1);
    idle(40);
    check("cd_secs", 32'(sec_cnt), 3);
    check("cd_timer", 32'(timer), 0);
    check("cd_run", 32'(timer_running), 0);

    // Play stage 0, score and lives
    cyc(4'b1010, 1'b1);
    check("play_load", 32'(timer), 30);
    done_cnt = 0;
    cyc(4'b0001, 1'b1); cyc(4'b0001, 1'b1); cyc(4'b0001, 1'b1);
    cyc(4'b0010, 1'b1);
    check("p_score", 32'(score), 3);
    check("p_lives", 32'(lives), 2);
    check("p_dones", 32'(done_cnt), 4);

    // Stage clear, held ready command
    cyc(4'b1100, 1'b1);
    done_cnt = 0;
    cyc(4'b1000, 1'b1); cyc(4'b1000, 1'b1);
    check("sc_stage", 32'(stage), 1);
    check("sc_dones", 32'(done_cnt), 1);
    check("sc_timer", 32'(timer), 3);
    cyc(4'b0101, 1'b1);
    idle(35);
    cyc(4'b1010, 1'b1);
    check("st1_load", 32'(timer), 25);

    // Saturation
    cyc(4'b0010, 1'b1); cyc(4'b0010, 1'b1); cyc(4'b0010, 1'b1);
    check("lives_sat", 32'(lives), 0);
    for (int i = 0; i < 1000; i++) cyc(4'b0001, 1'b1);
    check("score_sat", 32'(score), 999);
    cyc(4'b1100, 1'b1);
    cyc(4'b1000, 1'b1);
    cyc(4'b0001, 1'b1);
    check("ready_ill_done", 32'(done), 0);
    check("ready_ill_score", 32'(score), 999);

    // Game over restart
    cyc(4'b0101, 1'b1);
    idle(35);
    cyc(4'b1010, 1'b1);
    cyc(4'b1101, 1'b1);
    cyc(4'b1000, 1'b1);
    check("go_state", 32'(state), 0);
    check("go_stage", 32'(stage), 0);
    check("go_lives", 32'(lives), 3);
    check("go_score", 32'(score), 0);

    // Reset mid-countdown
    cyc(4'b0101, 1'b1);
    idle(14);
    async_reset();
    sec_cnt = 0;
    idle(30);
    check("rst_nosec", 32'(sec_cnt), 0);
    check("rst_timer", 32'(timer), 3);

    // Random commands
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] f;
      bit t;
      if ($urandom_range(0, 999) == 0) begin
        async_reset();
      end else begin
        f = ($urandom_range(0, 3) != 0) ? codes[$urandom_range(0, 7)] : 4'($urandom);
        t = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 2) == 0) begin f = 4'd0; t = 1'b0; end
        cyc(f, t);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_state_core.md
GAME_STATE_CORE -- requirements
Module: game_state_core

Interface
REQ-001 SHALL have parameters: TICK_DIV, default 1000000, clk_1mhz cycles per second; READY_SEC, default 3, ready countdown length; PLAY_SEC0..3, defaults 30/25/20/15, play seconds per stage.
REQ-002 clk_1mhz  in  1  system clock; one clock, all logic on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 flag  in  4  command code, sampled when trig=1.
REQ-005 trig  in  1  command valid, level-sampled every cycle.
REQ-006 done  out  1  one-cycle pulse, cycle after an accepted command.
REQ-007 sec_posedge  out  1  one-cycle pulse on each timer decrement.
REQ-008 timer_running  out  1  countdown active.
REQ-009 timer  out  7  seconds remaining.
REQ-010 state  out  3  0 ready, 1 playing, 3 game over, 4 stage clear, 5 game clear.
REQ-011 stage  out  2  current stage 0..3.
REQ-012 lives  out  2  lives remaining.
REQ-013 score  out  10  score 0..999.

Function
REQ-014 SHALL accept a command only when trig=1 and the command is legal in the current state; illegal or unknown commands SHALL be ignored with no done pulse.
REQ-015 Legality: 0001 score+1, playing only; 0010 lives-1, playing only; 0101 start countdown, ready with timer_running=0 and timer>0; 1010 to playing, ready with timer=0 and timer_running=0; 1100/1101/1110 to stage clear/game over/game clear, playing only; 1000 to ready, states 3/4/5 only.
REQ-016 Legality rules SHALL make a command repeated on consecutive cycles take effect once: a repeated 1000 SHALL NOT advance stage twice.
REQ-017 Score SHALL saturate at 999; lives SHALL saturate at 0.
REQ-018 0101 SHALL set timer_running and clear the prescaler.
REQ-019 1010 SHALL load timer=PLAY_SEC[stage], set timer_running and clear the prescaler.
REQ-020 1100/1101/1110 SHALL clear timer_running and hold timer.
REQ-021 1000 from stage clear SHALL increment stage (saturate 3) and keep score and lives; from game over/clear it SHALL set stage=0, lives=3, score=0; both SHALL load timer=READY_SEC with timer_running=0.
REQ-022 While timer_running=1, the prescaler SHALL count 0..TICK_DIV-1; on wrap, timer SHALL decrement and sec_posedge SHALL be high for the same cycle timer shows the new value.
REQ-023 A decrement to 0 SHALL clear timer_running on the same edge; timer SHALL never wrap below 0.
REQ-024 If an accepted command loads timer on the same cycle as a prescaler wrap, the load SHALL win and no sec_posedge SHALL be issued.
REQ-025 Latency: accepted command SHALL update outputs on the next edge, with done high for that one cycle.

Reset
REQ-026 Reset SHALL force state=0, stage=0, lives=3, score=0, timer=READY_SEC, timer_running=0, done=0, sec_posedge=0, prescaler=0.
REQ-027 Reset mid-countdown SHALL abandon the command and tick immediately; first tick after release SHALL need a new 0101.

Structure
REQ-028 State encodings, flag codes, READY_SEC and PLAY_SEC defaults SHALL live in shared package game_pkg, also used by the command issuer.
REQ-029 Prescaler and sec_posedge generation SHALL be one sub-module, sec_ticker, with clear, enable and tick ports.

Verification
REQ-030 Run benches with TICK_DIV=10.
REQ-031 Reset, then 0101 in ready -> timer 3,2,1,0 at 10-cycle spacing, 3 sec_posedge pulses, timer_running falls with timer=0.
REQ-032 1010 at stage 0, then 0001 three times and 0010 once -> timer=30, score=3, lives=2, 4 done pulses.
REQ-033 1100 then 1000 held for 2 cycles -> stage=1, one done pulse, timer=3; later 1010 loads 25.
REQ-034 lives=0 with 0010, score=999 with 0001, 0001 in ready -> values unchanged; no done pulse for the illegal ready command.
REQ-035 1101 then 1000 -> state=0, stage=0, lives=3, score=0; rst_n low mid-countdown -> all REQ-026 values asynchronously.
